// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and default widths for the flagged sync FIFO
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int FIFO_ADDR_WIDTH_DEF = 5;
    localparam int FIFO_DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH storage, one sync write port, one async read port
//
// Ports:
//   clk      in   rising-edge write clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  contents at rd_addr (combinational)
module fifo_mem import fifo_pkg::*; #(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage is deliberately not reset; the pointers define what is valid.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, almost flags, error pulses and FWFT option
//
// Ports:
//   clk           in   sole clock, rising edge
//   reset         in   asynchronous active-low reset
//   Wr_enable     in   write request
//   data_in       in   write data
//   Read_enable   in   read request
//   data_out      out  read data (registered in standard mode, head-of-queue in FWFT mode)
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AFULL_THRESH
//   almost_empty  out  count <= AEMPTY_THRESH
//   count         out  occupancy 0..DEPTH
//   overflow      out  one-cycle pulse after a rejected write
//   underflow     out  one-cycle pulse after a rejected read
module sync_fifo_flags import fifo_pkg::*; #(
    parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH    = FIFO_DATA_WIDTH_DEF,
    parameter int DEPTH         = 2 ** ADDR_WIDTH,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Wr_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  Read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    generate
        if (DEPTH != 2 ** ADDR_WIDTH) begin : g_bad_depth
            $error("sync_fifo_flags: DEPTH must equal 2**ADDR_WIDTH");
        end
        if (AFULL_THRESH <= 0 || AFULL_THRESH > DEPTH) begin : g_bad_afull
            $error("sync_fifo_flags: AFULL_THRESH out of range");
        end
        if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= DEPTH) begin : g_bad_aempty
            $error("sync_fifo_flags: AEMPTY_THRESH out of range");
        end
    endgenerate

    localparam fifo_mode_e          MODE     = fifo_mode_e'(FWFT != 0);
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH + 1)'(1);

    // Pointers carry an extra wrap bit; only the low bits address memory.
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  rd_ok;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] mem_rdata;

    fifo_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (mem_rdata)
    );

    // Flags decode the registered count only, so they never glitch on inputs.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A read at full frees a slot in the same cycle, so the write may proceed.
    assign rd_ok = Read_enable & ~empty;
    assign wr_ok = Wr_enable & (~full | rd_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        overflow_d  = Wr_enable & ~wr_ok;
        underflow_d = Read_enable & ~rd_ok;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end
        if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + ONE_C;
            data_out_d = mem_rdata;
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + ONE_C;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - ONE_C;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // FWFT presents the head entry directly; it reads as zero while empty so
    // uninitialised storage never reaches the port.
    always_comb begin
        data_out = data_out_q;
        if (MODE == FIFO_FWFT) begin
            data_out = empty ? '0 : mem_rdata;
        end
    end

endmodule
